dcache_thread_queue: RTL and testbench
======================================

DCACHE_THREAD_QUEUE -- requirements
Module: dcache_thread_queue

Interface
REQ-001 Parameter NUM_THREADS, default 2: number of hardware threads, one queue each, minimum 1.
REQ-002 Parameter DEPTH, default 4: entries per thread queue, minimum 2, any integer (not restricted to power of 2).
REQ-003 Parameter INFO_WIDTH, default 128: request payload width in bits, carried opaquely.
REQ-004 Derived widths SHALL be: TID_W = max(1, clog2(NUM_THREADS)); CNT_W = clog2(DEPTH+1).
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush_cache  in  NUM_THREADS  per-thread flush; bit t discards all of thread t's queued requests.
REQ-008 req_valid  in  1  request from ALU stage valid this cycle.
REQ-009 req_thread_id  in  TID_W  owning thread of the incoming request.
REQ-010 req_info  in  INFO_WIDTH  request payload.
REQ-011 req_ready  out  NUM_THREADS  bit t high when thread t's queue is not full (stall signal to pipeline).
REQ-012 issue_valid  out  1  head request presented to dTLB/D$.
REQ-013 issue_info  out  INFO_WIDTH  payload of presented request.
REQ-014 issue_thread_id  out  TID_W  thread of presented request.
REQ-015 issue_ready  in  1  dTLB/D$ accepts presented request this cycle.
REQ-016 occupancy  out  NUM_THREADS*CNT_W  entry count per thread, thread t at bits [t*CNT_W +: CNT_W].
REQ-017 drop_error  out  1  one-cycle pulse: a request was rejected because its queue was full.

Function
REQ-018 Each thread SHALL own an independent circular FIFO of DEPTH entries with read pointer, write pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-019 Enqueue to thread t SHALL occur when req_valid & req_thread_id==t & count[t]<DEPTH & !flush_cache[t].
REQ-020 req_ready[t] SHALL be count[t]<DEPTH from registered state only; it SHALL NOT depend on issue_ready (no full-queue bypass).
REQ-021 A request to a full queue SHALL be discarded, with no state change, and drop_error SHALL be high in the following cycle only.
REQ-022 No enqueue-to-issue bypass: a request enqueued at edge N SHALL be eligible for issue no earlier than the cycle after edge N.
REQ-023 Eligible thread: count[t]>0 and flush_cache[t]==0; issue_valid SHALL be high iff a selected thread is eligible.
REQ-024 Selection SHALL be round-robin: first eligible thread searching upward (with wrap) from rr_ptr; on handshake rr_ptr <= selected+1 mod NUM_THREADS.
REQ-025 Handshake (issue_valid & issue_ready) SHALL pop the selected thread's head at that edge.
REQ-026 If issue_valid is high and issue_ready low, selection SHALL be locked: issue_thread_id and issue_info stay unchanged until handshake, irrespective of other threads becoming eligible.
REQ-027 Flush of the locked thread SHALL deassert issue_valid combinationally that cycle and release the lock at the edge.
REQ-028 flush_cache[t] SHALL zero count[t], read and write pointers of t at the edge; flush has priority over a same-cycle enqueue or pop for t.
REQ-029 Simultaneous enqueue and pop on the same non-full thread SHALL leave count unchanged and advance both pointers.
REQ-030 Requests of a single thread SHALL issue strictly in enqueue order.
REQ-031 With NUM_THREADS==1, rr_ptr and issue_thread_id SHALL remain 0.

Reset
REQ-032 Reset SHALL clear all counts, pointers, rr_ptr, lock and drop_error; storage contents need not be cleared.
REQ-033 During and after reset: req_ready all ones, issue_valid 0, occupancy 0, drop_error 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued and locked requests at that edge, overriding any handshake.

Verification (NUM_THREADS=4, DEPTH=4, INFO_WIDTH=128)
REQ-035 Enqueue A0..A3 to thread 1, issue_ready=0 -> after 4th edge req_ready=4'b1101, occupancy[1]=4; 5th request A4 -> drop_error pulses once, occupancy[1] stays 4.
REQ-036 Threads 0,2,3 each hold 2 entries, issue_ready=1 continuously -> issue_thread_id sequence 0,2,3,0,2,3, then issue_valid=0.
REQ-037 Thread 2 presented with issue_ready=0, then thread 0 enqueues -> issue_thread_id stays 2 with unchanged issue_info until issue_ready=1.
REQ-038 Thread 1 locked with 3 entries, flush_cache[1]=1 for one cycle -> issue_valid 0 that cycle, occupancy[1]=0 next, same-cycle enqueue to thread 1 discarded without drop_error.
REQ-039 Thread 3 at 3 entries, enqueue and handshake same cycle for 6 cycles -> occupancy[3] stays 3, pointers wrap, payloads issue in order.
REQ-040 Reset asserted with all queues at 2 entries -> next cycle issue_valid=0, occupancy all 0, req_ready=4'b1111.

Source files
------------

// File: rtl/dcache_thread_queue.sv
// rtl/dcache_thread_queue.sv - per-thread request FIFOs with round-robin issue to the dTLB/D$
module dcache_thread_queue #(
  parameter int NUM_THREADS = 2,
  parameter int DEPTH       = 4,
  parameter int INFO_WIDTH  = 128,
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_THREADS-1:0]       flush_cache,
  input  logic                         req_valid,
  input  logic [TID_W-1:0]             req_thread_id,
  input  logic [INFO_WIDTH-1:0]        req_info,
  output logic [NUM_THREADS-1:0]       req_ready,
  output logic                         issue_valid,
  output logic [INFO_WIDTH-1:0]        issue_info,
  output logic [TID_W-1:0]             issue_thread_id,
  input  logic                         issue_ready,
  output logic [NUM_THREADS*CNT_W-1:0] occupancy,
  output logic                         drop_error
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [INFO_WIDTH-1:0] mem    [NUM_THREADS][DEPTH];
  logic [PTR_W-1:0]      rd_ptr [NUM_THREADS];
  logic [PTR_W-1:0]      wr_ptr [NUM_THREADS];
  logic [CNT_W-1:0]      count  [NUM_THREADS];
  logic [TID_W-1:0]      rr_ptr, lock_tid, sel, rr_next;
  logic                  lock_valid, drop_q, drop_any, handshake;
  logic [NUM_THREADS-1:0] full, eligible, enq, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    drop_any = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      full[t]     = (count[t] == FULL);
      eligible[t] = (count[t] != '0) && !flush_cache[t];
      enq[t]      = req_valid && (req_thread_id == TID_W'(t)) && !full[t] && !flush_cache[t];
      drop_any    = drop_any | (req_valid && (req_thread_id == TID_W'(t)) && full[t] && !flush_cache[t]);
    end
  end

  // A stalled presentation stays on its thread; otherwise scan downward so the
  // last hit is the first eligible thread at or after rr_ptr.
  always_comb begin
    sel = rr_ptr;
    if (lock_valid) begin
      sel = lock_tid;
    end else begin
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
        if (eligible[(int'(rr_ptr) + i) % NUM_THREADS])
          sel = TID_W'((int'(rr_ptr) + i) % NUM_THREADS);
      end
    end
  end

  always_comb begin
    issue_valid     = !reset && eligible[sel];
    issue_thread_id = sel;
    issue_info      = mem[sel][rd_ptr[sel]];
    handshake       = issue_valid && issue_ready;
    rr_next         = (int'(sel) + 1 >= NUM_THREADS) ? '0 : sel + TID_W'(1);
    drop_error      = drop_q && !reset;
    occupancy       = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      pop[t]       = handshake && (sel == TID_W'(t));
      req_ready[t] = reset || !full[t];
      occupancy[t*CNT_W +: CNT_W] = reset ? '0 : count[t];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        count[t]  <= '0;
        rd_ptr[t] <= '0;
        wr_ptr[t] <= '0;
      end
      rr_ptr     <= '0;
      lock_tid   <= '0;
      lock_valid <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= drop_any;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (flush_cache[t]) begin
          count[t]  <= '0;
          rd_ptr[t] <= '0;
          wr_ptr[t] <= '0;
        end else begin
          if (enq[t]) wr_ptr[t] <= ptr_inc(wr_ptr[t]);
          if (pop[t]) rd_ptr[t] <= ptr_inc(rd_ptr[t]);
          if (enq[t] && !pop[t])      count[t] <= count[t] + CNT_W'(1);
          else if (pop[t] && !enq[t]) count[t] <= count[t] - CNT_W'(1);
        end
      end
      if (handshake) begin
        rr_ptr     <= rr_next;
        lock_valid <= 1'b0;
      end else begin
        lock_valid <= issue_valid;
        lock_tid   <= sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int t = 0; t < NUM_THREADS; t++)
      if (enq[t]) mem[t][wr_ptr[t]] <= req_info;
  end
endmodule

// File: tb/tb_dcache_thread_queue.sv
// tb/tb_dcache_thread_queue.sv - randomized bench for dcache_thread_queue against a queue-based model
module tb_dcache_thread_queue;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   flush_cache = '0;
  logic         req_valid = 1'b0;
  logic [1:0]   req_thread_id = '0;
  logic [127:0] req_info = '0;
  logic [3:0]   req_ready;
  logic         issue_valid;
  logic [127:0] issue_info;
  logic [1:0]   issue_thread_id;
  logic         issue_ready = 1'b0;
  logic [11:0]  occupancy;
  logic         drop_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] mq [4][$];
  int m_rr = 0;
  int m_lock_tid = 0;
  bit m_lock = 0;
  bit m_drop = 0;

  dcache_thread_queue #(.NUM_THREADS(4), .DEPTH(4), .INFO_WIDTH(128)) dut (
    .clock(clock), .reset(reset), .flush_cache(flush_cache),
    .req_valid(req_valid), .req_thread_id(req_thread_id), .req_info(req_info),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_info(issue_info),
    .issue_thread_id(issue_thread_id), .issue_ready(issue_ready),
    .occupancy(occupancy), .drop_error(drop_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd_info();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive at negedge, compare presented outputs against the model,
  // then advance the model with the same inputs at the rising edge.
  task automatic cycle(input bit rst, input logic [3:0] fl, input bit rv, input int tid,
                       input logic [127:0] info, input bit ir);
    int  sel;
    bit  vld;
    bit  hs;
    int  sz [4];
    @(negedge clock);
    reset = rst; flush_cache = fl; req_valid = rv;
    req_thread_id = 2'(tid); req_info = info; issue_ready = ir;
    #1;
    vld = 0;
    sel = 0;
    if (!rst) begin
      if (m_lock) begin
        sel = m_lock_tid;
        vld = (mq[sel].size() > 0) && !fl[sel];
      end else begin
        for (int i = 0; i < 4; i++) begin
          int t;
          t = (m_rr + i) % 4;
          if (!vld && mq[t].size() > 0 && !fl[t]) begin
            vld = 1;
            sel = t;
          end
        end
      end
    end
    check("issue_valid", 128'(issue_valid), 128'(vld));
    if (vld) begin
      check("issue_thread_id", 128'(issue_thread_id), 128'(sel));
      check("issue_info", issue_info, mq[sel][0]);
    end
    for (int t = 0; t < 4; t++) begin
      check("req_ready", 128'(req_ready[t]), 128'(rst || mq[t].size() < 4));
      check("occupancy", 128'(occupancy[t*3 +: 3]), rst ? 128'(0) : 128'(mq[t].size()));
    end
    check("drop_error", 128'(drop_error), 128'(!rst && m_drop));
    @(posedge clock);
    if (rst) begin
      for (int t = 0; t < 4; t++) mq[t].delete();
      m_rr = 0; m_lock = 0; m_drop = 0;
    end else begin
      for (int t = 0; t < 4; t++) sz[t] = mq[t].size();
      hs = vld && ir;
      m_drop = rv && !fl[tid] && sz[tid] == 4;
      for (int t = 0; t < 4; t++) begin
        if (fl[t]) mq[t].delete();
        else begin
          if (hs && sel == t) void'(mq[t].pop_front());
          if (rv && tid == t && sz[t] < 4) mq[t].push_back(info);
        end
      end
      if (hs) begin
        m_rr = (sel + 1) % 4;
        m_lock = 0;
      end else begin
        m_lock = vld;
        m_lock_tid = sel;
      end
    end
  endtask

  initial begin
    int seq [6];
    logic [3:0] fl;
    seq[0] = 0; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 2; seq[5] = 3;

    repeat (2) cycle(1, 4'h0, 0, 0, '0, 0);
    cycle(0, 4'h0, 0, 0, '0, 0);

    for (int k = 0; k < 4; k++) cycle(0, 4'h0, 1, 1, rnd_info(), 0);
    #1;
    check("full_ready", 128'(req_ready), 128'(4'b1101));
    check("full_occ1", 128'(occupancy[5:3]), 128'(4));
    cycle(0, 4'h0, 1, 1, rnd_info(), 0);
    #1;
    check("drop_pulse", 128'(drop_error), 128'(1));
    cycle(0, 4'h0, 0, 0, '0, 0);
    #1;
    check("drop_clear", 128'(drop_error), 128'(0));
    check("drop_occ1", 128'(occupancy[5:3]), 128'(4));

    cycle(1, 4'h0, 0, 0, '0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 4'h0, 1, (k < 2) ? 0 : (k < 4) ? 2 : 3, rnd_info(), 0);
    #1;
    check("rr_seq", 128'(issue_thread_id), 128'(seq[0]));
    for (int k = 1; k < 6; k++) begin
      cycle(0, 4'h0, 0, 0, '0, 1);
      #1;
      check("rr_seq", 128'(issue_thread_id), 128'(seq[k]));
    end
    cycle(0, 4'h0, 0, 0, '0, 1);
    #1;
    check("rr_drained", 128'(issue_valid), 128'(0));

    for (int k = 0; k < 8; k++) cycle(0, 4'h0, 1, k % 4, rnd_info(), 0);
    cycle(1, 4'h0, 0, 0, '0, 1);
    #1;
    check("rst_valid", 128'(issue_valid), 128'(0));
    check("rst_occ", 128'(occupancy), 128'(0));
    check("rst_ready", 128'(req_ready), 128'(4'b1111));

    for (int blk = 0; blk < 15; blk++) begin
      int rpct;
      rpct = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        fl = '0;
        for (int t = 0; t < 4; t++) if ($urandom_range(0, 99) < 3) fl[t] = 1'b1;
        cycle($urandom_range(0, 199) == 0, fl, $urandom_range(0, 99) < 70,
              int'($urandom_range(0, 3)), rnd_info(), $urandom_range(0, 99) < rpct);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
